// File: rtl/ifu_fetch_if.sv
// Signal bundle for the fetch stage: EX redirect, instruction bus and the IF->ID handshake.
// master = fetch unit, slave = surrounding pipeline and bus.
interface ifu_fetch_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   redirect_i;
  logic [PC_WIDTH-1:0]    redirect_pc_i;
  logic                   ibus_req_valid_o;
  logic                   ibus_req_ready_i;
  logic [PC_WIDTH-1:0]    ibus_req_addr_o;
  logic                   ibus_rsp_valid_i;
  logic [INSTR_WIDTH-1:0] ibus_rsp_data_i;
  logic                   ibus_rsp_err_i;
  logic                   IF_valid_o;
  logic                   ID_ready_i;
  logic [PC_WIDTH-1:0]    IF_pc_o;
  logic [INSTR_WIDTH-1:0] ifu_instr_o;
  logic                   ifu_prdt_taken_o;
  logic                   ifu_pc_misalign_o;
  logic                   ifu_bus_err_o;

  modport master (
    input  redirect_i, redirect_pc_i, ibus_req_ready_i, ibus_rsp_valid_i,
           ibus_rsp_data_i, ibus_rsp_err_i, ID_ready_i,
    output ibus_req_valid_o, ibus_req_addr_o, IF_valid_o, IF_pc_o, ifu_instr_o,
           ifu_prdt_taken_o, ifu_pc_misalign_o, ifu_bus_err_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, ibus_req_ready_i, ibus_rsp_valid_i,
           ibus_rsp_data_i, ibus_rsp_err_i, ID_ready_i,
    input  ibus_req_valid_o, ibus_req_addr_o, IF_valid_o, IF_pc_o, ifu_instr_o,
           ifu_prdt_taken_o, ifu_pc_misalign_o, ifu_bus_err_o
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: two in-order outstanding requests, 2-entry output queue, EX redirect.
// Define IFU_STATIC_BP_EN to build static prediction (JAL and backward branches taken).
module ifu_fetch #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  // mode | meaning
  // RUN  | requests may be issued
  // HALT | stopped after a bus error or misaligned PC; only a redirect resumes
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} mode_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   prdt;
    logic                   misalign;
    logic                   err;
  } entry_t;

  mode_e               r_mode, w_mode_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [1:0]          r_out, w_out_nxt;
  logic [1:0]          r_drop, w_drop_nxt;
  logic [1:0]          r_cnt, w_cnt_nxt;
  logic                r_rd, w_rd_nxt;
  logic                r_wr, w_wr_nxt;
  logic                r_pcq_rd, r_pcq_wr;
  entry_t              r_q [2];
  logic [PC_WIDTH-1:0] r_pcq [2];

  logic                w_valid, w_pop, w_aligned, w_req, w_acc;
  logic                w_rsp_push, w_mis_push, w_push, w_prdt;
  logic [2:0]          w_occ;
  logic [PC_WIDTH-1:0] w_rsp_pc;
  entry_t              w_entry, w_head;

  assign w_valid   = (r_cnt != 2'd0);
  assign w_pop     = w_valid & bus.ID_ready_i;
  assign w_aligned = (r_pc[1:0] == 2'b00);
  // A same-cycle pop frees its slot before any response to a new request can land.
  assign w_occ     = {1'b0, r_out} + {1'b0, r_cnt} - {2'b00, w_pop};
  assign w_req     = !rst && !bus.redirect_i && (r_mode == RUN) && w_aligned && (w_occ < 3'd2);
  assign w_acc     = w_req & bus.ibus_req_ready_i;
  assign w_rsp_pc  = r_pcq[r_pcq_rd];

  assign w_rsp_push = bus.ibus_rsp_valid_i && (r_drop == 2'd0) && !bus.redirect_i;
  // Misaligned entry waits until every live response ahead of it has been queued.
  assign w_mis_push = !bus.redirect_i && (r_mode == RUN) && !w_aligned && (r_out == r_drop) &&
                      ((r_cnt - {1'b0, w_pop}) < 2'd2);
  assign w_push     = w_rsp_push | w_mis_push;

`ifdef IFU_STATIC_BP_EN
  logic [INSTR_WIDTH-1:0] w_d;
  logic                   w_is_jal, w_is_bbk;
  logic [PC_WIDTH-1:0]    w_jimm, w_bimm, w_target;

  assign w_d      = bus.ibus_rsp_data_i;
  assign w_is_jal = (w_d[6:0] == 7'b1101111);
  assign w_is_bbk = (w_d[6:0] == 7'b1100011) && w_d[31];
  assign w_jimm   = {{(PC_WIDTH-20){w_d[31]}}, w_d[19:12], w_d[20], w_d[30:21], 1'b0};
  assign w_bimm   = {{(PC_WIDTH-12){w_d[31]}}, w_d[7], w_d[30:25], w_d[11:8], 1'b0};
  assign w_target = w_rsp_pc + (w_is_jal ? w_jimm : w_bimm);
  assign w_prdt   = !bus.ibus_rsp_err_i && (w_is_jal || w_is_bbk);
`else
  assign w_prdt   = 1'b0;
`endif

  always_comb begin
    w_entry          = '0;
    w_entry.pc       = w_mis_push ? r_pc : w_rsp_pc;
    w_entry.misalign = w_mis_push;
    if (!w_mis_push) begin
      w_entry.instr = bus.ibus_rsp_err_i ? '0 : bus.ibus_rsp_data_i;
      w_entry.prdt  = w_prdt;
      w_entry.err   = bus.ibus_rsp_err_i;
    end
  end

  always_comb begin
    w_pc_nxt   = r_pc;
    w_mode_nxt = r_mode;
    w_out_nxt  = r_out - {1'b0, bus.ibus_rsp_valid_i} + {1'b0, w_acc};
    w_drop_nxt = r_drop - {1'b0, bus.ibus_rsp_valid_i && (r_drop != 2'd0)};
    w_cnt_nxt  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    w_rd_nxt   = r_rd ^ w_pop;
    w_wr_nxt   = r_wr ^ w_push;
    if (w_acc) w_pc_nxt = r_pc + PC_WIDTH'(4);
    if ((w_rsp_push && bus.ibus_rsp_err_i) || w_mis_push) w_mode_nxt = HALT;
`ifdef IFU_STATIC_BP_EN
    // Everything still in flight after a taken prediction is younger and gets discarded.
    if (w_rsp_push && w_prdt) begin
      w_pc_nxt   = w_target;
      w_drop_nxt = w_out_nxt;
    end
`endif
    if (bus.redirect_i) begin
      w_pc_nxt   = bus.redirect_pc_i;
      w_mode_nxt = RUN;
      w_out_nxt  = r_out - {1'b0, bus.ibus_rsp_valid_i};
      w_drop_nxt = r_out - {1'b0, bus.ibus_rsp_valid_i};
      w_cnt_nxt  = 2'd0;
      w_rd_nxt   = 1'b0;
      w_wr_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_mode <= RUN;
    else     r_mode <= w_mode_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_out    <= 2'd0;
      r_drop   <= 2'd0;
      r_cnt    <= 2'd0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_pcq_rd <= 1'b0;
      r_pcq_wr <= 1'b0;
      r_q[0]   <= '0;
      r_q[1]   <= '0;
      r_pcq[0] <= '0;
      r_pcq[1] <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_out  <= w_out_nxt;
      r_drop <= w_drop_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rd   <= w_rd_nxt;
      r_wr   <= w_wr_nxt;
      if (w_push) r_q[r_wr] <= w_entry;
      // PC FIFO tracks every request, dropped or not, so it never needs flushing.
      if (w_acc) begin
        r_pcq[r_pcq_wr] <= r_pc;
        r_pcq_wr        <= ~r_pcq_wr;
      end
      if (bus.ibus_rsp_valid_i) r_pcq_rd <= ~r_pcq_rd;
    end
  end

  assign w_head = r_q[r_rd];

  assign bus.ibus_req_valid_o  = w_req;
  assign bus.ibus_req_addr_o   = w_req ? r_pc : '0;
  assign bus.IF_valid_o        = w_valid;
  assign bus.IF_pc_o           = w_valid ? w_head.pc : '0;
  assign bus.ifu_instr_o       = w_valid ? w_head.instr : '0;
  assign bus.ifu_prdt_taken_o  = w_valid & w_head.prdt;
  assign bus.ifu_pc_misalign_o = w_valid & w_head.misalign;
  assign bus.ifu_bus_err_o     = w_valid & w_head.err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: per-cycle vector table plus redirect/misalign/error/prediction sequences.
module tb_ifu_fetch;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk, rst;
  ifu_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  ifu_fetch #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h8000_0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;
  logic        hold;
  logic [31:0] err_addr;
  logic [31:0] tbq [$];

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        exp_rv;
    logic [31:0] exp_ra;
    logic        chk_if;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;
  vec_t vecs [18];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == BASE + 32'h10) return 32'hFE00_0EE3;
    return {a[24:0], 7'b0010011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus model: requests accepted at an edge are answered in order, one per cycle, unless held.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = bus.ibus_req_valid_o & bus.ibus_req_ready_i;
    a   = bus.ibus_req_addr_o;
    @(posedge clk);
    #1;
    if (acc) tbq.push_back(a);
    if (!hold && tbq.size() != 0) begin
      a = tbq.pop_front();
      bus.ibus_rsp_valid_i = 1'b1;
      bus.ibus_rsp_data_i  = mem(a);
      bus.ibus_rsp_err_i   = (a == err_addr);
    end else begin
      bus.ibus_rsp_valid_i = 1'b0;
      bus.ibus_rsp_data_i  = '0;
      bus.ibus_rsp_err_i   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tbq.delete();
    bus.ibus_rsp_valid_i = 1'b0;
    bus.ibus_rsp_data_i  = '0;
    bus.ibus_rsp_err_i   = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    #2;
    chk("redirect_blocks_req", {31'b0, bus.ibus_req_valid_o}, 32'd0);
    tick();
    bus.redirect_i = 1'b0;
  endtask

  initial begin
    logic        found;
    logic [31:0] first_addr;
    int          nreq, nval, nc, ne, nafter;
    logic [31:0] c_pc [4], c_in [4], e_pc [8], e_in [8];
    logic        c_err [4], e_p [8], seen;
    logic        exp_p4;
    logic [31:0] exp_next;

    rst = 1'b1;
    hold = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.ibus_req_ready_i = 1'b1;
    bus.ibus_rsp_valid_i = 1'b0;
    bus.ibus_rsp_data_i = '0;
    bus.ibus_rsp_err_i = 1'b0;
    bus.ID_ready_i = 1'b1;

    //               rst   rdy   rv    ra            chk   iv    ipc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, BASE,         1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, BASE + 32'h8, 1'b1, 1'b1, BASE};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, BASE + 32'hC, 1'b1, 1'b1, BASE + 32'h4};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, BASE + 32'h10, 1'b1, 1'b1, BASE + 32'h8};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, BASE,         1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, BASE};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, BASE};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, BASE};
    vecs[14] = '{1'b0, 1'b1, 1'b1, BASE + 32'h8, 1'b1, 1'b1, BASE};
    vecs[15] = '{1'b0, 1'b1, 1'b1, BASE + 32'hC, 1'b1, 1'b1, BASE + 32'h4};
    vecs[16] = '{1'b0, 1'b1, 1'b1, BASE + 32'h10, 1'b1, 1'b1, BASE + 32'h8};
    vecs[17] = '{1'b0, 1'b1, 1'b1, BASE + 32'h14, 1'b1, 1'b1, BASE + 32'hC};

    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst;
      bus.ID_ready_i = vecs[i].rdy;
      #2;
      chk($sformatf("v%0d_req_valid", i), {31'b0, bus.ibus_req_valid_o}, {31'b0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) chk($sformatf("v%0d_req_addr", i), bus.ibus_req_addr_o, vecs[i].exp_ra);
      if (vecs[i].chk_if) begin
        chk($sformatf("v%0d_if_valid", i), {31'b0, bus.IF_valid_o}, {31'b0, vecs[i].exp_iv});
        chk($sformatf("v%0d_if_pc", i), bus.IF_pc_o, vecs[i].exp_ipc);
        chk($sformatf("v%0d_instr", i), bus.ifu_instr_o, vecs[i].exp_iv ? mem(vecs[i].exp_ipc) : 32'h0);
        chk($sformatf("v%0d_flags", i),
            {29'b0, bus.ifu_prdt_taken_o, bus.ifu_pc_misalign_o, bus.ifu_bus_err_o}, 32'h0);
      end
      tick();
    end

    // Redirect with two requests outstanding: both responses must be dropped.
    do_reset();
    hold = 1'b1;
    bus.ID_ready_i = 1'b1;
    #2;
    chk("A_req0_addr", bus.ibus_req_addr_o, BASE);
    tick();
    #2;
    chk("A_req1_addr", bus.ibus_req_addr_o, BASE + 32'h4);
    tick();
    #2;
    chk("A_two_outstanding_cap", {31'b0, bus.ibus_req_valid_o}, 32'd0);
    redirect_to(BASE + 32'h100);
    hold = 1'b0;
    found = 1'b0;
    first_addr = '0;
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (bus.ibus_req_valid_o && nreq == 0) begin
        first_addr = bus.ibus_req_addr_o;
        nreq++;
      end
      if (bus.IF_valid_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("A_valid_seen", {31'b0, found}, 32'd1);
    chk("A_first_req_addr", first_addr, BASE + 32'h100);
    chk("A_entry_pc", bus.IF_pc_o, BASE + 32'h100);
    chk("A_entry_instr", bus.ifu_instr_o, mem(BASE + 32'h100));
    tick();

    // Misaligned redirect: one misalign entry, no bus traffic, then halted.
    redirect_to(BASE + 32'h102);
    found = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (bus.ibus_req_valid_o) nreq++;
      if (bus.IF_valid_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("B_valid_seen", {31'b0, found}, 32'd1);
    chk("B_pc", bus.IF_pc_o, BASE + 32'h102);
    chk("B_misalign", {31'b0, bus.ifu_pc_misalign_o}, 32'd1);
    chk("B_instr", bus.ifu_instr_o, 32'h0);
    chk("B_err", {31'b0, bus.ifu_bus_err_o}, 32'd0);
    tick();
    nval = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (bus.ibus_req_valid_o) nreq++;
      if (bus.IF_valid_o) nval++;
      tick();
    end
    chk("B_no_requests", nreq, 0);
    chk("B_no_more_entries", nval, 0);

    // Bus error at BASE+8 halts fetch.
    err_addr = BASE + 32'h8;
    redirect_to(BASE);
    nc = 0;
    seen = 1'b0;
    nafter = 0;
    for (int i = 0; i < 4; i++) begin
      c_pc[i] = '0;
      c_in[i] = '0;
      c_err[i] = 1'b0;
    end
    for (int i = 0; i < 15; i++) begin
      #2;
      if (bus.IF_valid_o && !seen && nc < 4) begin
        c_pc[nc] = bus.IF_pc_o;
        c_in[nc] = bus.ifu_instr_o;
        c_err[nc] = bus.ifu_bus_err_o;
        if (bus.ifu_bus_err_o) seen = 1'b1;
        nc++;
      end
      if (seen && bus.ibus_req_valid_o) nafter++;
      tick();
    end
    chk("C_err_seen", {31'b0, seen}, 32'd1);
    chk("C_entries", nc, 3);
    chk("C_pc0", c_pc[0], BASE);
    chk("C_pc1", c_pc[1], BASE + 32'h4);
    chk("C_instr1", c_in[1], mem(BASE + 32'h4));
    chk("C_err1", {31'b0, c_err[1]}, 32'd0);
    chk("C_pc2", c_pc[2], BASE + 32'h8);
    chk("C_err2", {31'b0, c_err[2]}, 32'd1);
    chk("C_instr2", c_in[2], 32'h0);
    chk("C_halt_no_requests", nafter, 0);

    // Backward branch FE000EE3 at BASE+0x10.
    err_addr = 32'hFFFF_FFFF;
    redirect_to(BASE);
    ne = 0;
    for (int i = 0; i < 8; i++) begin
      e_pc[i] = '0;
      e_in[i] = '0;
      e_p[i] = 1'b0;
    end
    for (int i = 0; i < 30; i++) begin
      #2;
      if (bus.IF_valid_o && ne < 7) begin
        e_pc[ne] = bus.IF_pc_o;
        e_in[ne] = bus.ifu_instr_o;
        e_p[ne] = bus.ifu_prdt_taken_o;
        ne++;
      end
      tick();
    end
`ifdef IFU_STATIC_BP_EN
    exp_p4 = 1'b1;
    exp_next = BASE + 32'hC;
`else
    exp_p4 = 1'b0;
    exp_next = BASE + 32'h14;
`endif
    chk("D_entries", ne, 7);
    chk("D_pc3", e_pc[3], BASE + 32'hC);
    chk("D_prdt3", {31'b0, e_p[3]}, 32'd0);
    chk("D_pc4", e_pc[4], BASE + 32'h10);
    chk("D_instr4", e_in[4], 32'hFE00_0EE3);
    chk("D_prdt4", {31'b0, e_p[4]}, {31'b0, exp_p4});
    chk("D_next_pc", e_pc[5], exp_next);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
